// File: rtl/xor_reg.sv
// rtl/xor_reg.sv - registered bitwise XOR with parity and configurable pipeline depth
// Stage 0 is combinational; LATENCY stages of {parity, xor} follow.
module xor_reg #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             parity
);

  logic [WIDTH-1:0] x;
  logic             p;

  assign x = a ^ b;
  assign p = ^x;

  if (WIDTH < 1 || WIDTH > 64 || LATENCY < 0 || LATENCY > 8) begin : g_bad_params
    $error("xor_reg: illegal parameters WIDTH=%0d LATENCY=%0d", WIDTH, LATENCY);
  end

  if (LATENCY == 0) begin : g_comb
    assign out    = x;
    assign parity = p;
  end else begin : g_pipe
    // Zero initialiser gives simulation a defined pre-reset state.
    logic [WIDTH:0] stage [LATENCY] = '{default: '0};

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
      end else begin
        stage[0] <= {p, x};
        for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
      end
    end

    assign out    = stage[LATENCY-1][WIDTH-1:0];
    assign parity = stage[LATENCY-1][WIDTH];
  end

endmodule

// File: tb/tb_xor_reg.sv
// tb/tb_xor_reg.sv - directed and reference-model checks of xor_reg in five configurations
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next one.
module tb_xor_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // default config
  logic       rst1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, o1;
  logic       p1;
  xor_reg u_w1l1 (.clk(clk), .rst(rst1), .a(a1), .b(b1), .out(o1), .parity(p1));

  // WIDTH=8, LATENCY=1
  logic       rst8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, o8;
  logic       p8;
  xor_reg #(.WIDTH(8), .LATENCY(1)) u_w8l1 (.clk(clk), .rst(rst8), .a(a8), .b(b8), .out(o8), .parity(p8));

  // WIDTH=4, LATENCY=3
  logic       rst4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, o4;
  logic       p4;
  xor_reg #(.WIDTH(4), .LATENCY(3)) u_w4l3 (.clk(clk), .rst(rst4), .a(a4), .b(b4), .out(o4), .parity(p4));

  // WIDTH=4, LATENCY=0
  logic       rstc = 1'b0;
  logic [3:0] ac = '0, bc = '0, oc;
  logic       pc;
  xor_reg #(.WIDTH(4), .LATENCY(0)) u_w4l0 (.clk(clk), .rst(rstc), .a(ac), .b(bc), .out(oc), .parity(pc));

  // WIDTH=16, LATENCY=2
  logic        rstr = 1'b0;
  logic [15:0] ar = '0, br = '0, orr;
  logic        pr;
  xor_reg #(.WIDTH(16), .LATENCY(2)) u_w16l2 (.clk(clk), .rst(rstr), .a(ar), .b(br), .out(orr), .parity(pr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // LATENCY=3 stream: input, reset, expected out/parity after that edge
  logic [3:0] s_in  [10] = '{4'h3, 4'h5, 4'hA, 4'hF, 4'h6, 4'h9, 4'hC, 4'h7, 4'h1, 4'h2};
  logic       s_rst [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
  logic [3:0] s_out [10] = '{4'h0, 4'h0, 4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 4'h9, 4'hC, 4'h7};
  logic       s_par [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  logic [1:0]  v_ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic        v_exp [4] = '{0, 1, 1, 0};

  logic [16:0] m1, m2;
  logic [15:0] rx;

  initial begin
    // Default config, no reset: zero before the first edge
    #1;
    check("w1_pre_edge_out", 64'(o1), 64'h0);
    check("w1_pre_edge_par", 64'(p1), 64'h0);
    for (int i = 0; i < 4; i++) begin
      a1 = v_ab[i][1];
      b1 = v_ab[i][0];
      tick();
      check($sformatf("w1_vec%0d_out", i), 64'(o1), 64'(v_exp[i]));
      check($sformatf("w1_vec%0d_par", i), 64'(p1), 64'(v_exp[i]));
    end

    // Reset priority over capture
    a1 = 1'b1;
    b1 = 1'b0;
    rst1 = 1'b1;
    tick();
    check("w1_rst_cyc0", 64'(o1), 64'h0);
    tick();
    check("w1_rst_cyc1", 64'(o1), 64'h0);
    rst1 = 1'b0;
    tick();
    check("w1_post_rst_out", 64'(o1), 64'h1);
    check("w1_post_rst_par", 64'(p1), 64'h1);

    // WIDTH=8
    a8 = 8'hF0;
    b8 = 8'h3C;
    tick();
    check("w8_a_out", 64'(o8), 64'hCC);
    check("w8_a_par", 64'(p8), 64'h0);
    a8 = 8'hFF;
    b8 = 8'h01;
    tick();
    check("w8_b_out", 64'(o8), 64'hFE);
    check("w8_b_par", 64'(p8), 64'h1);

    // WIDTH=4, LATENCY=3: clear, stream, mid-stream reset
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a4 = s_in[i];
      b4 = 4'h0;
      rst4 = s_rst[i];
      tick();
      check($sformatf("l3_c%0d_out", i + 1), 64'(o4), 64'(s_out[i]));
      check($sformatf("l3_c%0d_par", i + 1), 64'(p4), 64'(s_par[i]));
    end
    rst4 = 1'b0;

    // LATENCY=0: combinational, reset ignored
    ac = 4'b1010;
    bc = 4'b0110;
    #1;
    check("l0_out", 64'(oc), 64'hC);
    check("l0_par", 64'(pc), 64'h0);
    rstc = 1'b1;
    #1;
    check("l0_rst_out", 64'(oc), 64'hC);
    tick();
    check("l0_rst_edge_out", 64'(oc), 64'hC);
    ac = 4'b0111;
    bc = 4'b0000;
    #1;
    check("l0_b_out", 64'(oc), 64'h7);
    check("l0_b_par", 64'(pc), 64'h1);
    rstc = 1'b0;

    // WIDTH=16, LATENCY=2: two-stage delay model with synchronous clear
    m1 = '0;
    m2 = '0;
    for (int i = 0; i < 1000; i++) begin
      ar = 16'($urandom);
      br = 16'($urandom);
      rstr = ($urandom_range(0, 15) == 0);
      rx = ar ^ br;
      @(posedge clk);
      if (rstr) begin
        m2 = '0;
        m1 = '0;
      end else begin
        m2 = m1;
        m1 = {^rx, rx};
      end
      #1;
      check($sformatf("rnd%0d_out", i), 64'(orr), 64'(m2[15:0]));
      check($sformatf("rnd%0d_par", i), 64'(pr), 64'(m2[16]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
